pipe_int_ctrl: RTL and testbench
================================

PIPE_INT_CTRL -- requirements
Module: pipe_int_ctrl

Interface
REQ-001 Parameter DRAIN_CYC, default 2, number of cycles the pipeline drains before interrupt vectoring (legal range 1..15).
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 irq  in  1  external interrupt request, level, asynchronous to clk.
REQ-005 id_valid  in  1  decode stage holds a valid instruction.
REQ-006 id_branch  in  1  branch/jump resolved taken in decode this cycle.
REQ-007 id_reti  in  1  decode instruction is return-from-interrupt.
REQ-008 id_rs0, id_rs1  in  5 each  decode source register indices.
REQ-009 x_memrd, x_rd  in  1, 5  execute-stage instruction is a load, and its destination register.
REQ-010 mem_busy  in  1  data memory is not ready; the pipeline must hold.
REQ-011 stall_fd  out  1  hold the PC and the fetch/decode register.
REQ-012 bubble_dx  out  1  insert a NOP into the decode/execute register.
REQ-013 flush_fd  out  1  squash the fetch/decode register.
REQ-014 inter  out  1  decode selects vector PC 0x00000000 for branch calculation.
REQ-015 ilr_we  out  1  write the return PC into ILR (register 31).
REQ-016 in_isr  out  1  interrupt service in progress; further interrupts are masked.
REQ-017 st  out  3  current state: IDLE=0, DRAIN=1, VECTOR=2, ISR=3, RETURN=4.

Function
REQ-018 irq SHALL pass through a 2-flop synchronizer; a third flop SHALL detect the rising edge.
REQ-019 A detected edge SHALL set irq_pend on that clock edge.
REQ-020 irq_pend SHALL clear on entry to VECTOR.
REQ-021 An edge detected in any state other than IDLE SHALL remain pending until it is serviced.
REQ-022 IDLE->DRAIN SHALL occur when irq_pend && !id_branch && !mem_busy; a taken branch defers entry by at least one cycle.
REQ-023 DRAIN entry SHALL load a 4-bit counter with DRAIN_CYC-1.
REQ-024 In DRAIN, when !mem_busy: count==0 SHALL go to VECTOR, otherwise the counter SHALL decrement; when mem_busy, the counter SHALL hold.
REQ-025 In DRAIN, stall_fd and bubble_dx SHALL be 1.
REQ-026 VECTOR SHALL last exactly one cycle with inter=1, ilr_we=1, flush_fd=1, then go to ISR.
REQ-027 In VECTOR, stall_fd and bubble_dx SHALL be 0.
REQ-028 ISR SHALL hold in_isr=1 and go to RETURN when id_valid && id_reti && !stall_fd.
REQ-029 RETURN SHALL last one cycle with flush_fd=1 and in_isr=1, then go to IDLE.
REQ-030 A pending interrupt SHALL NOT leave IDLE earlier than one cycle after RETURN.
REQ-031 Load-use hazard = id_valid && x_memrd && x_rd!=0 && (x_rd==id_rs0 || x_rd==id_rs1).
REQ-032 In IDLE or ISR, a load-use hazard SHALL combinationally drive stall_fd=1 and bubble_dx=1.
REQ-033 In IDLE or ISR, mem_busy SHALL combinationally drive stall_fd=1 only.
REQ-034 All other outputs SHALL be Moore (decoded from the state only).
REQ-035 In VECTOR and RETURN, the hazard SHALL be ignored; the flush takes precedence.
REQ-036 Unused state encodings SHALL return to IDLE on the next edge.

Reset
REQ-037 On rst_n low: st=IDLE, counter=0, irq_pend=0, synchronizer flops=0.
REQ-038 During reset, all outputs SHALL be 0 apart from hazard/mem_busy-derived stall_fd and bubble_dx; all outputs SHALL be 0 when the inputs are idle.
REQ-039 Reset asserted mid-DRAIN, VECTOR or ISR SHALL abandon the sequence; the interrupt SHALL NOT be replayed after reset.

Verification
REQ-040 irq 0->1 before edge 1, no blockers, DRAIN_CYC=2 -> st=DRAIN after edge 4, VECTOR after edge 6 (inter=ilr_we=flush_fd=1 for one cycle), ISR after edge 7.
REQ-041 irq pending with id_branch=1 for 2 cycles -> st stays IDLE for those cycles, enters DRAIN on the first edge with id_branch=0.
REQ-042 mem_busy=1 for 3 cycles in DRAIN -> counter holds, VECTOR delayed 3 cycles, stall_fd=1 throughout.
REQ-043 x_memrd=1, x_rd=5, id_rs1=5, id_valid=1 in IDLE -> stall_fd=bubble_dx=1 that cycle; x_rd=0 -> no stall.
REQ-044 Second irq edge during ISR, then id_reti -> RETURN, IDLE for 1 cycle, then DRAIN; second VECTOR occurs.
REQ-045 rst_n pulsed low during DRAIN -> st=IDLE, irq_pend=0, no VECTOR afterward with irq held high.

Source files
------------

// File: rtl/pipe_int_ctrl.sv
// Pipeline interrupt controller: synchronises irq, drains the pipeline, vectors to the ISR
// and returns, while also resolving load-use and memory-wait stalls in decode.
module pipe_int_ctrl #(
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq,
  input  logic       id_valid,
  input  logic       id_branch,
  input  logic       id_reti,
  input  logic [4:0] id_rs0,
  input  logic [4:0] id_rs1,
  input  logic       x_memrd,
  input  logic [4:0] x_rd,
  input  logic       mem_busy,
  output logic       stall_fd,
  output logic       bubble_dx,
  output logic       flush_fd,
  output logic       inter,
  output logic       ilr_we,
  output logic       in_isr,
  output logic [2:0] st
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    VECTOR = 3'd2,
    ISR    = 3'd3,
    RETURN = 3'd4
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYC - 32'd1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic [2:0] sync_q;
  logic [1:0] prime_q;
  logic       hazard_s;
  logic       edge_s;

  // The edge detector stays blind until the chain holds three real samples, so an irq
  // already high when reset is released is never mistaken for a fresh request.
  assign edge_s   = sync_q[1] & ~sync_q[2] & (prime_q == 2'd3);
  assign hazard_s = id_valid & x_memrd & (x_rd != 5'd0) & ((x_rd == id_rs0) | (x_rd == id_rs1));
  assign pend_d   = edge_s | (pend_q & ~((state_q == DRAIN) & (state_d == VECTOR)));
  assign st       = state_q;

  // Synchroniser, priming counter and pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 3'd0;
      prime_q <= 2'd0;
      pend_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], irq};
      prime_q <= (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
      pend_q  <= pend_d;
    end
  end

  // State and drain counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and drain counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pend_q && !id_branch && !mem_busy) begin
          state_d = DRAIN;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (!mem_busy) begin
          if (cnt_q == 4'd0) begin
            state_d = VECTOR;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      VECTOR: state_d = ISR;
      ISR: begin
        if (id_valid && id_reti && !stall_fd) begin
          state_d = RETURN;
        end else begin
          state_d = ISR;
        end
      end
      RETURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; only IDLE and ISR let the hazard and memory wait through
  always_comb begin
    stall_fd  = 1'b0;
    bubble_dx = 1'b0;
    flush_fd  = 1'b0;
    inter     = 1'b0;
    ilr_we    = 1'b0;
    in_isr    = 1'b0;
    case (state_q)
      IDLE: begin
        stall_fd  = hazard_s | mem_busy;
        bubble_dx = hazard_s;
      end
      DRAIN: begin
        stall_fd  = 1'b1;
        bubble_dx = 1'b1;
      end
      VECTOR: begin
        flush_fd = 1'b1;
        inter    = 1'b1;
        ilr_we   = 1'b1;
      end
      ISR: begin
        in_isr    = 1'b1;
        stall_fd  = hazard_s | mem_busy;
        bubble_dx = hazard_s;
      end
      RETURN: begin
        flush_fd = 1'b1;
        in_isr   = 1'b1;
      end
      default: begin
        stall_fd = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// Bench for pipe_int_ctrl: directed scenarios plus randomised traffic, all checked
// against a phase-level reference model of the interrupt sequence.
module tb_pipe_int_ctrl;
  localparam int DC = 2;

  logic       clk = 1'b0;
  logic       rst_n, irq, id_valid, id_branch, id_reti, x_memrd, mem_busy;
  logic [4:0] id_rs0, id_rs1, x_rd;
  logic       stall_fd, bubble_dx, flush_fd, inter, ilr_we, in_isr;
  logic [2:0] st;

  int checks   = 0;
  int failures = 0;

  // reference model: phase (0 idle,1 drain,2 vector,3 isr,4 return), drain cycles left,
  // pending flag, irq sample history and clocks since reset
  int         m_ph, m_rem, m_age;
  bit         m_pend;
  bit   [2:0] m_sy;
  logic [8:0] exp_v;

  pipe_int_ctrl #(.DRAIN_CYC(DC)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .id_valid(id_valid), .id_branch(id_branch),
    .id_reti(id_reti), .id_rs0(id_rs0), .id_rs1(id_rs1), .x_memrd(x_memrd), .x_rd(x_rd),
    .mem_busy(mem_busy), .stall_fd(stall_fd), .bubble_dx(bubble_dx), .flush_fd(flush_fd),
    .inter(inter), .ilr_we(ilr_we), .in_isr(in_isr), .st(st)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {st, stall_fd, bubble_dx, flush_fd, inter, ilr_we, in_isr};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_rem = 0; m_age = 0; m_pend = 1'b0; m_sy = 3'd0;
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; id_branch = 1'b0; id_reti = 1'b0; x_memrd = 1'b0; mem_busy = 1'b0;
    id_rs0 = 5'd0; id_rs1 = 5'd0; x_rd = 5'd0;
  endtask

  // let combinational outputs settle and form the model's expected output word
  task automatic settle();
    bit haz;
    #2;
    haz = id_valid && x_memrd && (x_rd != 5'd0) && (x_rd == id_rs0 || x_rd == id_rs1);
    exp_v[8:6] = 3'(m_ph);
    exp_v[5]   = (m_ph == 1) || ((m_ph == 0 || m_ph == 3) && (haz || mem_busy));
    exp_v[4]   = (m_ph == 1) || ((m_ph == 0 || m_ph == 3) && haz);
    exp_v[3]   = (m_ph == 2 || m_ph == 4);
    exp_v[2]   = (m_ph == 2);
    exp_v[1]   = (m_ph == 2);
    exp_v[0]   = (m_ph == 3 || m_ph == 4);
  endtask

  // advance the model by one clock with the current inputs, then cross the edge
  task automatic tick();
    bit edge_seen;
    int nph;
    if (!rst_n) begin
      model_reset();
    end else begin
      edge_seen = m_sy[1] && !m_sy[2] && (m_age >= 3);
      nph = m_ph;
      case (m_ph)
        0: if (m_pend && !id_branch && !mem_busy) begin nph = 1; m_rem = DC; end
        1: if (!mem_busy) begin m_rem--; if (m_rem == 0) nph = 2; end
        2: nph = 3;
        3: if (id_valid && id_reti && !exp_v[5]) nph = 4;
        default: nph = 0;
      endcase
      m_pend = edge_seen || (m_pend && !(m_ph == 1 && nph == 2));
      m_sy   = {m_sy[1:0], irq};
      m_age++;
      m_ph   = nph;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic leave_isr();
    id_valid = 1'b1; id_reti = 1'b1;
    for (int r = 0; r < 3; r++) begin
      settle(); checks++;
      if (obs() !== exp_v) begin failures++; $display("FAIL leave_isr r=%0d got=%b want=%b", r, obs(), exp_v); end
      tick();
      idle_inputs();
    end
  endtask

  task automatic quiet_cycles(input int n);
    irq = 1'b0; idle_inputs();
    for (int i = 0; i < n; i++) begin
      settle(); checks++;
      if (obs() !== exp_v) begin failures++; $display("FAIL quiet got=%b want=%b", obs(), exp_v); end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq = 1'b0; idle_inputs(); model_reset();
    settle(); checks++;
    if (obs() !== 9'b000000000) begin failures++; $display("FAIL reset_idle got=%b want=%b", obs(), 9'b000000000); end
    id_valid = 1'b1; x_memrd = 1'b1; x_rd = 5'd5; id_rs1 = 5'd5;
    settle(); checks++;
    if (obs() !== 9'b000110000) begin failures++; $display("FAIL reset_hazard got=%b want=%b", obs(), 9'b000110000); end
    tick();
    rst_n = 1'b1;
    quiet_cycles(5);
  endtask

  task automatic test_irq_basic();
    int st_tab [8] = '{0, 0, 0, 0, 1, 1, 2, 3};
    irq = 1'b1;
    for (int n = 0; n < 8; n++) begin
      settle(); checks++;
      if (st !== 3'(st_tab[n])) begin failures++; $display("FAIL basic_st n=%0d got=%0d want=%0d", n, st, st_tab[n]); end
      checks++;
      if (obs() !== exp_v) begin failures++; $display("FAIL basic_model n=%0d got=%b want=%b", n, obs(), exp_v); end
      if (n == 6) begin
        checks++;
        if ({inter, ilr_we, flush_fd} !== 3'b111) begin failures++; $display("FAIL basic_vector got=%b want=111", {inter, ilr_we, flush_fd}); end
      end
      tick();
    end
    leave_isr();
    checks++;
    if (st !== 3'd0) begin failures++; $display("FAIL basic_back_idle got=%0d want=0", st); end
    quiet_cycles(3);
  endtask

  task automatic test_branch_defer();
    irq = 1'b1;
    for (int n = 0; n < 10; n++) begin
      id_branch = (n == 3 || n == 4);
      settle(); checks++;
      if (obs() !== exp_v) begin failures++; $display("FAIL branch_model n=%0d got=%b want=%b", n, obs(), exp_v); end
      if (n == 4 || n == 5) begin
        checks++;
        if (st !== 3'd0) begin failures++; $display("FAIL branch_hold n=%0d got=%0d want=0", n, st); end
      end
      if (n == 6) begin
        checks++;
        if (st !== 3'd1) begin failures++; $display("FAIL branch_drain got=%0d want=1", st); end
      end
      tick();
    end
    id_branch = 1'b0;
    leave_isr();
    quiet_cycles(3);
  endtask

  task automatic test_mem_busy_drain();
    int st_tab [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 3};
    irq = 1'b1;
    for (int n = 0; n < 11; n++) begin
      mem_busy = (n >= 4 && n <= 6);
      settle(); checks++;
      if (st !== 3'(st_tab[n])) begin failures++; $display("FAIL busy_st n=%0d got=%0d want=%0d", n, st, st_tab[n]); end
      checks++;
      if (obs() !== exp_v) begin failures++; $display("FAIL busy_model n=%0d got=%b want=%b", n, obs(), exp_v); end
      if (n >= 4 && n <= 8) begin
        checks++;
        if (stall_fd !== 1'b1) begin failures++; $display("FAIL busy_stall n=%0d got=%b want=1", n, stall_fd); end
      end
      tick();
    end
    mem_busy = 1'b0;
    leave_isr();
    quiet_cycles(3);
  endtask

  task automatic test_load_use();
    // {valid, memrd, busy, rs0, rs1, xrd, want_stall, want_bubble}
    logic [20:0] tab [6] = '{
      {1'b1, 1'b1, 1'b0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1},
      {1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0},
      {1'b0, 1'b1, 1'b0, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0},
      {1'b1, 1'b0, 1'b0, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0},
      {1'b1, 1'b0, 1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0},
      {1'b1, 1'b1, 1'b0, 5'd3, 5'd4, 5'd3, 1'b1, 1'b1}};
    logic [20:0] row;
    for (int k = 0; k < 6; k++) begin
      row = tab[k];
      {id_valid, x_memrd, mem_busy, id_rs0, id_rs1, x_rd} = row[20:2];
      settle(); checks++;
      if ({stall_fd, bubble_dx} !== row[1:0]) begin failures++; $display("FAIL load_use k=%0d got=%b want=%b", k, {stall_fd, bubble_dx}, row[1:0]); end
      checks++;
      if (obs() !== exp_v) begin failures++; $display("FAIL load_use_model k=%0d got=%b want=%b", k, obs(), exp_v); end
      tick();
    end
    quiet_cycles(1);
  endtask

  task automatic test_second_irq();
    int st_tab [7] = '{3, 4, 0, 1, 1, 2, 3};
    irq = 1'b1;
    for (int n = 0; n < 15; n++) begin
      if (n == 8) irq = 1'b0;
      if (n == 11) irq = 1'b1;
      settle(); checks++;
      if (obs() !== exp_v) begin failures++; $display("FAIL second_prep n=%0d got=%b want=%b", n, obs(), exp_v); end
      tick();
    end
    for (int r = 0; r < 7; r++) begin
      id_valid = (r == 0); id_reti = (r == 0);
      settle(); checks++;
      if (st !== 3'(st_tab[r])) begin failures++; $display("FAIL second_st r=%0d got=%0d want=%0d", r, st, st_tab[r]); end
      checks++;
      if (obs() !== exp_v) begin failures++; $display("FAIL second_model r=%0d got=%b want=%b", r, obs(), exp_v); end
      tick();
    end
    leave_isr();
    quiet_cycles(3);
  endtask

  task automatic test_reset_mid_drain();
    irq = 1'b1;
    for (int n = 0; n < 6; n++) begin
      settle(); checks++;
      if (obs() !== exp_v) begin failures++; $display("FAIL rstmid_model n=%0d got=%b want=%b", n, obs(), exp_v); end
      tick();
    end
    rst_n = 1'b0; model_reset();
    settle(); checks++;
    if (obs() !== 9'b000000000) begin failures++; $display("FAIL rstmid_abandon got=%b want=%b", obs(), 9'b000000000); end
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      settle(); checks++;
      if (st !== 3'd0 || inter !== 1'b0) begin failures++; $display("FAIL rstmid_replay n=%0d got st=%0d inter=%b want st=0 inter=0", n, st, inter); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(249) == 0) begin rst_n = 1'b0; model_reset(); end
      if ($urandom_range(9) == 0) irq = ~irq;
      id_valid  = ($urandom_range(3) != 0);
      id_branch = ($urandom_range(3) == 0);
      id_reti   = ($urandom_range(4) == 0);
      x_memrd   = ($urandom_range(2) == 0);
      mem_busy  = ($urandom_range(4) == 0);
      id_rs0    = 5'($urandom_range(3));
      id_rs1    = 5'($urandom_range(3));
      x_rd      = 5'($urandom_range(3));
      settle(); checks++;
      if (obs() !== exp_v) begin failures++; $display("FAIL random n=%0d got=%b want=%b", n, obs(), exp_v); end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_irq_basic();
    test_branch_defer();
    test_mem_busy_drain();
    test_load_use();
    test_second_irq();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
